// File: rtl/sm_arith_pkg.sv
// Shared types for the sign-magnitude add/subtract pipeline.
// Operation encoding lives here so every stage agrees on it.
package sm_arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/sm_compare_swap.sv
// Combinational front end: folds the operation into B's sign, then orders
// the two magnitudes so the adder stage only ever subtracts small from big.
module sm_compare_swap
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-2:0] mag_big_o,
    output logic [WIDTH-2:0] mag_small_o,
    output logic             sign_o,
    output logic             diff_signs_o
);

    localparam int SIGN_POS_IN = WIDTH - 1;

    logic [WIDTH-2:0] w_mag_a;
    logic [WIDTH-2:0] w_mag_b;
    logic             w_sign_a;
    logic             w_sign_b_eff;
    logic             w_a_is_big;

    assign w_mag_a      = a_i[SIGN_POS_IN-1:0];
    assign w_mag_b      = b_i[SIGN_POS_IN-1:0];
    assign w_sign_a     = a_i[SIGN_POS_IN];
    assign w_sign_b_eff = b_i[SIGN_POS_IN] ^ (op_i == OP_SUB);

    // Ties go to A so equal magnitudes inherit A's sign.
    assign w_a_is_big   = (w_mag_a >= w_mag_b);

    assign mag_big_o    = w_a_is_big ? w_mag_a : w_mag_b;
    assign mag_small_o  = w_a_is_big ? w_mag_b : w_mag_a;
    assign sign_o       = w_a_is_big ? w_sign_a : w_sign_b_eff;
    assign diff_signs_o = w_sign_a ^ w_sign_b_eff;

endmodule

// File: rtl/sign_magnitude_addsub_pipe.sv
// Two-stage valid/ready sign-magnitude adder/subtractor: stage 1 holds the
// ordered magnitudes, stage 2 holds the finished result.
module sign_magnitude_addsub_pipe
    import sm_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH:0]   sum_o,
    output logic             zero_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int MAG_W        = WIDTH - 1;
    localparam int SIGN_POS_OUT = WIDTH;

    typedef struct packed {
        logic [MAG_W-1:0] mag_big;
        logic [MAG_W-1:0] mag_small;
        logic             sign;
        logic             diff_signs;
    } s1_payload_t;

    s1_payload_t      w_s1_next;
    s1_payload_t      r_s1;
    logic             r_s1_valid;
    logic [WIDTH:0]   r_sum;
    logic             r_zero;
    logic             r_s2_valid;

    logic             w_s2_load;
    logic [WIDTH-1:0] w_big_ext;
    logic [WIDTH-1:0] w_small_ext;
    logic [WIDTH-1:0] w_mag;
    logic             w_zero;
    logic             w_sign;

    sm_compare_swap #(
        .WIDTH(WIDTH)
    ) u_compare_swap (
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_t'(op_i)),
        .mag_big_o   (w_s1_next.mag_big),
        .mag_small_o (w_s1_next.mag_small),
        .sign_o      (w_s1_next.sign),
        .diff_signs_o(w_s1_next.diff_signs)
    );

    assign w_s2_load = !r_s2_valid || ready_i;
    assign ready_o   = !r_s1_valid || w_s2_load;

    // The extra top bit absorbs the carry, so the sum can never overflow.
    assign w_big_ext   = {1'b0, r_s1.mag_big};
    assign w_small_ext = {1'b0, r_s1.mag_small};
    assign w_mag       = r_s1.diff_signs ? (w_big_ext - w_small_ext)
                                         : (w_big_ext + w_small_ext);
    assign w_zero      = (w_mag == '0);
    assign w_sign      = r_s1.sign && !w_zero;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (ready_o) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_zero     <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= {w_sign, w_mag};
                r_zero <= w_zero;
            end
        end
    end

    // Gate the payload so a drained stage never shows its last result.
    assign valid_o = r_s2_valid;
    assign sum_o   = r_s2_valid ? r_sum : '0;
    assign zero_o  = r_s2_valid && r_zero;

    logic w_unused_sign_pos;
    assign w_unused_sign_pos = sum_o[SIGN_POS_OUT];

endmodule

// File: tb/tb_sign_magnitude_addsub_pipe.sv
// Self-checking bench: directed literal vectors plus a signed-integer
// reference model compared against every output transfer.
module tb_sign_magnitude_addsub_pipe;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rstIn;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             opIn;
    logic             validIn;
    logic             readyOut;
    logic [WIDTH:0]   sumOut;
    logic             zeroOut;
    logic             validOut;
    logic             readyIn;

    int total = 0;
    int bad = 0;
    int outCount = 0;
    bit randReady = 0;

    logic [WIDTH+1:0] expQueue[$];
    logic             prevRst = 0;
    logic             prevStall = 0;
    logic [WIDTH:0]   prevSum = '0;
    logic             prevZero = 0;

    sign_magnitude_addsub_pipe #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rstIn),
        .a_i    (aIn),
        .b_i    (bIn),
        .op_i   (opIn),
        .valid_i(validIn),
        .ready_o(readyOut),
        .sum_o  (sumOut),
        .zero_o (zeroOut),
        .valid_o(validOut),
        .ready_i(readyIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: decode both operands to signed integers and do plain arithmetic.
    function automatic logic [WIDTH+1:0] modelResult(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic op);
        int sa;
        int sb;
        int r;
        int m;
        logic [WIDTH:0] s;
        sa = int'(a[WIDTH-2:0]);
        sb = int'(b[WIDTH-2:0]);
        if (a[WIDTH-1]) sa = -sa;
        if (b[WIDTH-1]) sb = -sb;
        r = op ? (sa - sb) : (sa + sb);
        m = (r < 0) ? -r : r;
        s[WIDTH] = (r < 0);
        s[WIDTH-1:0] = m[WIDTH-1:0];
        return {s, (m == 0)};
    endfunction

    // Single compare process, sampled mid-cycle when everything is settled.
    always @(negedge clk) begin
        logic [WIDTH+1:0] exp;
        if (prevRst) begin
            checkOutput("rstValidLow", validOut, 0);
            checkOutput("rstReadyHigh", readyOut, 1);
        end else if (prevStall) begin
            checkOutput("holdValid", validOut, 1);
            checkOutput("holdSum", sumOut, prevSum);
            checkOutput("holdZero", zeroOut, prevZero);
        end
        if (!validOut) begin
            checkOutput("idleSumZero", {sumOut, zeroOut}, 0);
        end
        if (validOut && readyIn) begin
            outCount++;
            if (expQueue.size() == 0) begin
                checkOutput("spuriousValid", validOut, 0);
            end else begin
                exp = expQueue.pop_front();
                checkOutput("modelSum", sumOut, exp[WIDTH+1:1]);
                checkOutput("modelZero", zeroOut, exp[0]);
            end
        end
        prevStall = validOut && !readyIn && !rstIn;
        prevSum   = sumOut;
        prevZero  = zeroOut;
        prevRst   = rstIn;
        if (rstIn) begin
            expQueue.delete();
        end else if (validIn && readyOut) begin
            expQueue.push_back(modelResult(aIn, bIn, opIn));
        end
    end

    task automatic sendTxn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic op);
        int waited = 0;
        bit accepted = 0;
        aIn = a;
        bIn = b;
        opIn = op;
        validIn = 1'b1;
        while (!accepted) begin
            @(negedge clk);
            accepted = readyOut;
            @(posedge clk);
            #1;
            if (randReady) readyIn = ($urandom_range(0, 3) != 0);
            if (!accepted) begin
                waited++;
                if (waited > 200) begin
                    checkOutput("acceptTimeout", readyOut, 1);
                    accepted = 1;
                end
            end
        end
        validIn = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic op,
                                 input logic [WIDTH:0] expSum, input logic expZero);
        sendTxn(a, b, op);
        checkOutput({name, "_lat1"}, validOut, 0);
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"}, validOut, 1);
        checkOutput({name, "_sum"}, sumOut, expSum);
        checkOutput({name, "_zero"}, zeroOut, expZero);
        @(posedge clk);
        #1;
        checkOutput({name, "_oneCycle"}, validOut, 0);
    endtask

    initial begin
        int base;
        int budget;
        rstIn = 1'b1;
        aIn = '0;
        bIn = '0;
        opIn = 1'b0;
        validIn = 1'b0;
        readyIn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetValid", validOut, 0);
        checkOutput("resetReady", readyOut, 1);
        checkOutput("resetSum", sumOut, 0);
        checkOutput("resetZero", zeroOut, 0);
        rstIn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postResetReady", readyOut, 1);

        applyStimulus("p3p2add", 4'b0011, 4'b0010, 1'b0, 5'b00101, 1'b0);
        applyStimulus("p3m7add", 4'b0011, 4'b1111, 1'b0, 5'b10100, 1'b0);
        applyStimulus("m7p7sub", 4'b1111, 4'b0111, 1'b1, 5'b11110, 1'b0);
        applyStimulus("p5p5sub", 4'b0101, 4'b0101, 1'b1, 5'b00000, 1'b1);
        applyStimulus("nz_nz_add", 4'b1000, 4'b1000, 1'b0, 5'b00000, 1'b1);
        applyStimulus("nz_p3_sub", 4'b1000, 4'b0011, 1'b1, 5'b10011, 1'b0);

        // Backpressure: two transactions fill the pipe, the third must wait.
        readyIn = 1'b0;
        sendTxn(4'b0001, 4'b0001, 1'b0);
        sendTxn(4'b0010, 4'b0011, 1'b0);
        aIn = 4'b0110;
        bIn = 4'b1010;
        opIn = 1'b0;
        validIn = 1'b1;
        @(negedge clk);
        checkOutput("stallReady", readyOut, 0);
        checkOutput("stallSum", sumOut, 5'b00010);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stallSumLate", sumOut, 5'b00010);
        readyIn = 1'b1;
        base = outCount;
        sendTxn(4'b0110, 4'b1010, 1'b0);
        sendTxn(4'b1100, 4'b0100, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("burstCount", outCount - base, 4);
        checkOutput("burstEnd", validOut, 0);

        // Reset with two transactions in flight.
        sendTxn(4'b0001, 4'b0010, 1'b0);
        sendTxn(4'b0011, 4'b0100, 1'b0);
        rstIn = 1'b1;
        aIn = 4'b0111;
        bIn = 4'b0111;
        validIn = 1'b1;
        @(posedge clk);
        #1;
        rstIn = 1'b0;
        validIn = 1'b0;
        checkOutput("midRstValid", validOut, 0);
        checkOutput("midRstReady", readyOut, 1);
        checkOutput("midRstSum", sumOut, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noStaleOut", validOut, 0);

        // Full sweep of operands and ops with random gaps and backpressure.
        randReady = 1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int op = 0; op < 2; op++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                        readyIn = ($urandom_range(0, 3) != 0);
                    end
                    sendTxn(4'(a), 4'(b), 1'(op));
                end
            end
        end
        randReady = 0;
        readyIn = 1'b1;
        budget = 0;
        while (expQueue.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        checkOutput("drainEmpty", expQueue.size(), 0);
        checkOutput("drainIdle", validOut, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
